uart_rx: RTL

UART receiver. It deserialises the asynchronous RX line into bytes and presents each byte on RX_DATA together with a one-cycle RECEIVED_8_BITS_FLAG. It sits directly upstream of the UART/RAM bridge: the bridge writes RX_DATA to RAM and advances the RAM address on each flag pulse. Frame format is 8N1, LSB first, with an optional parity bit.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default sizing.
// Intended for reuse by uart_rx and a future uart_tx.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
  localparam int unsigned UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs.
// Ports:
//   i_clk    - destination clock
//   i_rst_n  - asynchronous active-low reset (both flops load RESET_VAL)
//   i_async  - asynchronous input
//   o_sync   - synchronised output, two cycles of latency
module uart_sync2 #(
  parameter int unsigned WIDTH     = 1,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= {WIDTH{RESET_VAL}};
      r_sync <= {WIDTH{RESET_VAL}};
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, optional even parity.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data).
// Ports:
//   MAIN_CLOCK           - system clock, rising edge
//   RESET_N              - asynchronous active-low reset
//   RX_SERIAL            - asynchronous serial line, idles high
//   RX_DATA              - last good byte, held until the next good frame
//   RECEIVED_8_BITS_FLAG - one-cycle pulse when RX_DATA is updated
//   RX_BUSY              - high while a frame is being received
//   FRAMING_ERROR        - one-cycle pulse when the stop bit samples 0
//   PARITY_ERROR         - one-cycle pulse on parity mismatch (0 without parity)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 MAIN_CLOCK,
  input  logic                 RESET_N,
  input  logic                 RX_SERIAL,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RECEIVED_8_BITS_FLAG,
  output logic                 RX_BUSY,
  output logic                 FRAMING_ERROR,
  output logic                 PARITY_ERROR
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_flag;
  logic                 r_busy;
  logic                 r_ferr;
  logic                 w_rx_s;
  logic                 w_par_ok;

  // Bring the serial line into the clock domain; idle-high reset value.
  uart_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk   (MAIN_CLOCK),
    .i_rst_n (RESET_N),
    .i_async (RX_SERIAL),
    .o_sync  (w_rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_perr;

  // Even parity: the parity bit equals the XOR of the data bits.
  assign w_par_ok     = (r_par_bit == ^r_shift);
  assign PARITY_ERROR = r_perr;
`else
  assign w_par_ok     = 1'b1;
  assign PARITY_ERROR = 1'b0;
`endif

  // Receive FSM; every bit after the start bit is sampled one full bit
  // period after the previous sample, i.e. at mid-bit.
  always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_flag    <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_flag <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject short glitches.
        START: begin
          if (r_clk_cnt == HALF_CNT) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (r_clk_cnt == FULL_CNT) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_clk_cnt == FULL_CNT) begin
            r_clk_cnt <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
`endif

        // Leave at mid stop bit so a following start edge is not missed.
        STOP: begin
          if (r_clk_cnt == FULL_CNT) begin
            r_clk_cnt <= '0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            if (w_rx_s && w_par_ok) begin
              r_data <= r_shift;
              r_flag <= 1'b1;
            end
            if (!w_rx_s) begin
              r_ferr <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (!w_par_ok) begin
              r_perr <= 1'b1;
            end
`endif
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  assign RX_DATA              = r_data;
  assign RECEIVED_8_BITS_FLAG = r_flag;
  assign RX_BUSY              = r_busy;
  assign FRAMING_ERROR        = r_ferr;

endmodule
